// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// FSM states, instruction classes, opcode/funct and ALU codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_JUMP,
        S_JR
    } state_t;

    typedef enum logic [3:0] {
        C_LW,
        C_SW,
        C_RTYPE_ADD,
        C_MUL,
        C_LUI,
        C_ORI,
        C_J,
        C_JR,
        C_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_SPEC2 = 6'h1C;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_MUL = 6'h02;

    localparam logic [3:0] ALU_LUI    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_PASS_A = 4'b0111;
    localparam logic [3:0] ALU_MUL    = 4'b0110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SIMM = 2'b10;
    localparam logic [1:0] SRCB_ZIMM = 2'b11;

    localparam logic [1:0] PC_ALU  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b10;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct classifier for the multicycle controller.
// Anything outside the supported set maps to C_ILLEGAL.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    always_comb begin
        iclass = C_ILLEGAL;
        unique case (1'b1)
            (opcode == OP_LW):  iclass = C_LW;
            (opcode == OP_SW):  iclass = C_SW;
            (opcode == OP_LUI): iclass = C_LUI;
            (opcode == OP_ORI): iclass = C_ORI;
            (opcode == OP_J):   iclass = C_J;
            (opcode == OP_RTYPE && funct == FN_ADD):
                iclass = C_RTYPE_ADD;
            (opcode == OP_RTYPE && funct == FN_JR):
                iclass = C_JR;
            (opcode == OP_SPEC2 && funct == FN_MUL):
                iclass = C_MUL;
            default: iclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch, decode, memory,
// execute and writeback steps and drives the datapath selects.
module mips_mc_ctrl
    import mips_pkg::*;
#(
    parameter logic [3:0] ALU_ADD_SEL = 4'b0010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [3:0] alu_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal
);

    state_t  r_state;
    state_t  w_next;
    iclass_t r_cls;
    iclass_t w_cls;
    logic [3:0] w_r_alu;

    mips_ctrl_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (w_cls)
    );

    // Class is latched only in DECODE so later opcode changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cls   <= C_ILLEGAL;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_cls <= w_cls;
            end
        end
    end

    assign w_r_alu = (r_cls == C_MUL) ? ALU_MUL : ALU_ADD_SEL;

    always_comb begin
        w_next     = r_state;
        alu_sel    = ALU_ADD_SEL;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PC_ALU;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        pc_write = 1'b1;
                        ir_write = 1'b1;
                        w_next   = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        C_LW, C_SW:         w_next = S_MEM_ADDR;
                        C_RTYPE_ADD, C_MUL: w_next = S_EXEC_R;
                        C_LUI, C_ORI:       w_next = S_EXEC_I;
                        C_J:                w_next = S_JUMP;
                        C_JR:               w_next = S_JR;
                        default: begin
                            illegal = 1'b1;
                            w_next  = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_SIMM;
                    w_next    = (r_cls == C_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        w_next = S_MEM_WB;
                    end
                end
                S_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        w_next = S_FETCH;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    w_next     = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_sel   = w_r_alu;
                    w_next    = S_R_WB;
                end
                S_R_WB: begin
                    alu_src_a = 1'b1;
                    alu_sel   = w_r_alu;
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    w_next    = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    if (r_cls == C_LUI) begin
                        alu_sel   = ALU_LUI;
                        alu_src_b = SRCB_SIMM;
                    end else begin
                        alu_sel   = ALU_OR;
                        alu_src_b = SRCB_ZIMM;
                    end
                    w_next = S_I_WB;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    w_next    = S_FETCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_JUMP;
                    w_next   = S_FETCH;
                end
                S_JR: begin
                    alu_src_a = 1'b1;
                    alu_sel   = ALU_PASS_A;
                    pc_write  = 1'b1;
                    w_next    = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule
